// File: rtl/wb_selfcheck_if.sv
// Bundle of the checker's load, writeback-monitor and status signals.
// Latency: none, wires only.
// Backpressure: exp_valid/exp_ready handshake on the expected-entry load path.
// Ports (signals):
//   exp_valid/exp_ready/exp_rd/exp_data : expected (rd, value) load channel
//   start                               : begin check / re-arm
//   wb_en/wb_rd/wb_data                 : monitored register-file write port
//   busy/done/pass/timeout              : run status
//   pass_cnt/fail_cnt                   : match / mismatch counters
//   first_fail_idx/rd/data              : capture of the first mismatch
// master = stimulus side (core / bench), slave = the checker.
interface wb_selfcheck_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int DEPTH = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             exp_valid;
    logic             exp_ready;
    logic [REG_W-1:0] exp_rd;
    logic [XLEN-1:0]  exp_data;
    logic             start;
    logic             wb_en;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [REG_W-1:0] first_fail_rd;
    logic [XLEN-1:0]  first_fail_data;

    modport master (
        output exp_valid, exp_rd, exp_data, start, wb_en, wb_rd, wb_data,
        input  exp_ready, busy, done, pass, timeout, pass_cnt, fail_cnt,
               first_fail_idx, first_fail_rd, first_fail_data
    );

    modport slave (
        input  exp_valid, exp_rd, exp_data, start, wb_en, wb_rd, wb_data,
        output exp_ready, busy, done, pass, timeout, pass_cnt, fail_cnt,
               first_fail_idx, first_fail_rd, first_fail_data
    );
endinterface

// File: rtl/wb_selfcheck.sv
// Writeback checker: queue of expected (rd, value) pairs compared in order against real writebacks.
// Latency: counters, first-fail capture and state update one cycle after the consuming writeback.
// Backpressure: exp_ready low outside IDLE or when the queue is full; the core is never stalled.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : wb_selfcheck_if.slave carrying load channel, start, writeback monitor and status
module wb_selfcheck #(
    parameter int XLEN         = 32,
    parameter int REG_W        = 5,
    parameter int DEPTH        = 32,
    parameter int TIMEOUT      = 1024,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic           clk,
    input  logic           rst,
    wb_selfcheck_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [REG_W-1:0] q_rd   [DEPTH];
    logic [XLEN-1:0]  q_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] occ_q;

    logic [TO_W-1:0]  wd_q;
    logic             timeout_q;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q, ff_idx_q;
    logic [REG_W-1:0] ff_rd_q;
    logic [XLEN-1:0]  ff_data_q;

    logic in_idle, in_run, in_done;
    logic full, empty, push, pop, mismatch, last_pop, expire, rearm;

    assign in_idle  = (state_q == S_IDLE);
    assign in_run   = (state_q == S_RUN);
    assign in_done  = (state_q == S_DONE);
    assign full     = (occ_q == CNT_W'(DEPTH));
    assign empty    = (occ_q == '0);
    assign push     = bus.exp_valid && in_idle && !full;
    // x0 writes are architectural no-ops, so they never consume an entry.
    assign pop      = in_run && bus.wb_en && (bus.wb_rd != '0) && !empty;
    assign mismatch = pop && ((q_rd[rd_ptr_q] != bus.wb_rd) || (q_data[rd_ptr_q] != bus.wb_data));
    assign last_pop = pop && (occ_q == CNT_W'(1));
    // Fires on the edge where the counter would reach TIMEOUT; a pop on that edge wins.
    assign expire   = in_run && !pop && (wd_q == TO_W'(TIMEOUT - 1));
    assign rearm    = in_done && bus.start;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Nothing to check: report an immediate pass.
                if (bus.start) state_d = empty ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (last_pop || expire || ((STOP_ON_FAIL != 0) && mismatch)) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_rd[wr_ptr_q]   <= bus.exp_rd;
            q_data[wr_ptr_q] <= bus.exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rearm) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ff_idx_q   <= '0;
            ff_rd_q    <= '0;
            ff_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                occ_q    <= occ_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                occ_q    <= occ_q - CNT_W'(1);
                if (mismatch) begin
                    fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                    if (fail_cnt_q == '0) begin
                        // No earlier failure, so the pop index equals the match count.
                        ff_idx_q  <= pass_cnt_q;
                        ff_rd_q   <= bus.wb_rd;
                        ff_data_q <= bus.wb_data;
                    end
                end else begin
                    pass_cnt_q <= pass_cnt_q + CNT_W'(1);
                end
            end
            if (in_idle && bus.start)  wd_q <= '0;
            else if (in_run && pop)    wd_q <= '0;
            else if (in_run && !expire) wd_q <= wd_q + TO_W'(1);
            if (expire) timeout_q <= 1'b1;
        end
    end

    assign bus.exp_ready       = in_idle && !full;
    assign bus.busy            = in_run;
    assign bus.done            = in_done;
    assign bus.pass            = in_done && (fail_cnt_q == '0) && !timeout_q;
    assign bus.timeout         = timeout_q;
    assign bus.pass_cnt        = pass_cnt_q;
    assign bus.fail_cnt        = fail_cnt_q;
    assign bus.first_fail_idx  = ff_idx_q;
    assign bus.first_fail_rd   = ff_rd_q;
    assign bus.first_fail_data = ff_data_q;
endmodule

// File: tb/tb_wb_selfcheck.sv
// Directed bench for wb_selfcheck: three instances (default, STOP_ON_FAIL=1, DEPTH=4/TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_wb_selfcheck;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_selfcheck_if #(.XLEN(32), .REG_W(5), .DEPTH(32)) if0 ();
    wb_selfcheck_if #(.XLEN(32), .REG_W(5), .DEPTH(32)) if1 ();
    wb_selfcheck_if #(.XLEN(32), .REG_W(5), .DEPTH(4))  if2 ();

    wb_selfcheck #(.XLEN(32), .REG_W(5), .DEPTH(32), .TIMEOUT(1024), .STOP_ON_FAIL(0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    wb_selfcheck #(.XLEN(32), .REG_W(5), .DEPTH(32), .TIMEOUT(1024), .STOP_ON_FAIL(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    wb_selfcheck #(.XLEN(32), .REG_W(5), .DEPTH(4), .TIMEOUT(8), .STOP_ON_FAIL(0))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input int u, input logic v, input logic [4:0] rd, input logic [31:0] d);
        case (u)
            0: begin if0.exp_valid = v; if0.exp_rd = rd; if0.exp_data = d; end
            1: begin if1.exp_valid = v; if1.exp_rd = rd; if1.exp_data = d; end
            default: begin if2.exp_valid = v; if2.exp_rd = rd; if2.exp_data = d; end
        endcase
    endtask

    task automatic set_wb(input int u, input logic en, input logic [4:0] rd, input logic [31:0] d);
        case (u)
            0: begin if0.wb_en = en; if0.wb_rd = rd; if0.wb_data = d; end
            1: begin if1.wb_en = en; if1.wb_rd = rd; if1.wb_data = d; end
            default: begin if2.wb_en = en; if2.wb_rd = rd; if2.wb_data = d; end
        endcase
    endtask

    task automatic set_start(input int u, input logic s);
        case (u)
            0: if0.start = s;
            1: if1.start = s;
            default: if2.start = s;
        endcase
    endtask

    task automatic load(input int u, input logic [4:0] rd, input logic [31:0] d);
        set_exp(u, 1'b1, rd, d);
        tick();
        set_exp(u, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic pulse_start(input int u);
        set_start(u, 1'b1);
        tick();
        set_start(u, 1'b0);
    endtask

    task automatic wb(input int u, input logic [4:0] rd, input logic [31:0] d);
        set_wb(u, 1'b1, rd, d);
        tick();
        set_wb(u, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (if0.busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", if0.busy); else n_pass++;
        n_checks++; if (if0.done !== 1'b0) $display("FAIL reset_done got %0h want 0", if0.done); else n_pass++;
        n_checks++; if (if0.pass !== 1'b0) $display("FAIL reset_pass got %0h want 0", if0.pass); else n_pass++;
        n_checks++; if (if0.timeout !== 1'b0) $display("FAIL reset_timeout got %0h want 0", if0.timeout); else n_pass++;
        n_checks++; if (if0.pass_cnt !== 6'd0) $display("FAIL reset_pass_cnt got %0d want 0", if0.pass_cnt); else n_pass++;
        n_checks++; if (if0.first_fail_data !== 32'd0) $display("FAIL reset_ff_data got %0h want 0", if0.first_fail_data); else n_pass++;
        n_checks++; if (if0.exp_ready !== 1'b1) $display("FAIL reset_exp_ready got %0h want 1", if0.exp_ready); else n_pass++;
        n_checks++; if (if2.exp_ready !== 1'b1) $display("FAIL reset_exp_ready2 got %0h want 1", if2.exp_ready); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load(0, 5'd1, 32'd1);
        load(0, 5'd2, 32'd2);
        load(0, 5'd3, 32'd3);
        pulse_start(0);
        n_checks++; if (if0.busy !== 1'b1) $display("FAIL basic_busy got %0h want 1", if0.busy); else n_pass++;
        n_checks++; if (if0.exp_ready !== 1'b0) $display("FAIL basic_ready_run got %0h want 0", if0.exp_ready); else n_pass++;
        wb(0, 5'd1, 32'd1);
        n_checks++; if (if0.pass_cnt !== 6'd1) $display("FAIL basic_cnt1 got %0d want 1", if0.pass_cnt); else n_pass++;
        pulse_start(0);  // ignored while running
        n_checks++; if (if0.busy !== 1'b1) $display("FAIL basic_start_in_run got busy %0h want 1", if0.busy); else n_pass++;
        wb(0, 5'd2, 32'd2);
        wb(0, 5'd3, 32'd3);
        n_checks++; if (if0.done !== 1'b1) $display("FAIL basic_done got %0h want 1", if0.done); else n_pass++;
        n_checks++; if (if0.pass !== 1'b1) $display("FAIL basic_pass got %0h want 1", if0.pass); else n_pass++;
        n_checks++; if (if0.pass_cnt !== 6'd3) $display("FAIL basic_pass_cnt got %0d want 3", if0.pass_cnt); else n_pass++;
        n_checks++; if (if0.fail_cnt !== 6'd0) $display("FAIL basic_fail_cnt got %0d want 0", if0.fail_cnt); else n_pass++;
        pulse_start(0);
        n_checks++; if (if0.done !== 1'b0) $display("FAIL basic_rearm_done got %0h want 0", if0.done); else n_pass++;
        n_checks++; if (if0.pass_cnt !== 6'd0) $display("FAIL basic_rearm_cnt got %0d want 0", if0.pass_cnt); else n_pass++;
    endtask

    task automatic test_mismatch();
        load(0, 5'd11, 32'hDEADBEEF);
        load(0, 5'd12, 32'h0000000A);
        load(0, 5'd13, 32'h0000000B);
        pulse_start(0);
        wb(0, 5'd0, 32'd5);  // x0 write ignored
        n_checks++; if ((if0.pass_cnt !== 6'd0) || (if0.fail_cnt !== 6'd0))
            $display("FAIL mm_x0_ignored got pass %0d fail %0d want 0 0", if0.pass_cnt, if0.fail_cnt); else n_pass++;
        wb(0, 5'd11, 32'hDEADBEEE);
        n_checks++; if (if0.fail_cnt !== 6'd1) $display("FAIL mm_fail_cnt got %0d want 1", if0.fail_cnt); else n_pass++;
        set_wb(0, 1'b0, 5'd12, 32'h0000000A);  // wb_en low: ignored
        tick();
        n_checks++; if (if0.pass_cnt !== 6'd0) $display("FAIL mm_en_low got %0d want 0", if0.pass_cnt); else n_pass++;
        wb(0, 5'd12, 32'h0000000A);
        wb(0, 5'd14, 32'h0000000B);  // rd differs
        n_checks++; if (if0.fail_cnt !== 6'd2) $display("FAIL mm_fail_cnt2 got %0d want 2", if0.fail_cnt); else n_pass++;
        n_checks++; if (if0.pass_cnt !== 6'd1) $display("FAIL mm_pass_cnt got %0d want 1", if0.pass_cnt); else n_pass++;
        n_checks++; if (if0.first_fail_idx !== 6'd0) $display("FAIL mm_ff_idx got %0d want 0", if0.first_fail_idx); else n_pass++;
        n_checks++; if (if0.first_fail_rd !== 5'd11) $display("FAIL mm_ff_rd got %0d want 11", if0.first_fail_rd); else n_pass++;
        n_checks++; if (if0.first_fail_data !== 32'hDEADBEEE) $display("FAIL mm_ff_data got %0h want deadbeee", if0.first_fail_data); else n_pass++;
        n_checks++; if ((if0.done !== 1'b1) || (if0.pass !== 1'b0))
            $display("FAIL mm_done_pass got done %0h pass %0h want 1 0", if0.done, if0.pass); else n_pass++;
        wb(0, 5'd11, 32'hDEADBEEF);  // ignored in DONE
        n_checks++; if (if0.pass_cnt !== 6'd1) $display("FAIL mm_done_ignored got %0d want 1", if0.pass_cnt); else n_pass++;
        pulse_start(0);
        n_checks++; if ((if0.fail_cnt !== 6'd0) || (if0.first_fail_data !== 32'd0))
            $display("FAIL mm_rearm got fail %0d data %0h want 0 0", if0.fail_cnt, if0.first_fail_data); else n_pass++;
    endtask

    task automatic test_empty_start();
        pulse_start(0);
        n_checks++; if ((if0.done !== 1'b1) || (if0.pass !== 1'b1))
            $display("FAIL empty_done_pass got done %0h pass %0h want 1 1", if0.done, if0.pass); else n_pass++;
        n_checks++; if (if0.pass_cnt !== 6'd0) $display("FAIL empty_cnt got %0d want 0", if0.pass_cnt); else n_pass++;
        pulse_start(0);
    endtask

    task automatic test_stop_on_fail();
        load(1, 5'd1, 32'd10);
        load(1, 5'd2, 32'd20);
        load(1, 5'd3, 32'd30);
        load(1, 5'd4, 32'd40);
        pulse_start(1);
        wb(1, 5'd1, 32'd10);
        n_checks++; if (if1.busy !== 1'b1) $display("FAIL sof_busy got %0h want 1", if1.busy); else n_pass++;
        wb(1, 5'd2, 32'd21);
        n_checks++; if (if1.done !== 1'b1) $display("FAIL sof_done got %0h want 1", if1.done); else n_pass++;
        n_checks++; if ((if1.pass_cnt !== 6'd1) || (if1.fail_cnt !== 6'd1))
            $display("FAIL sof_counts got pass %0d fail %0d want 1 1", if1.pass_cnt, if1.fail_cnt); else n_pass++;
        n_checks++; if ((if1.first_fail_idx !== 6'd1) || (if1.first_fail_data !== 32'd21))
            $display("FAIL sof_ff got idx %0d data %0d want 1 21", if1.first_fail_idx, if1.first_fail_data); else n_pass++;
        wb(1, 5'd3, 32'd30);
        n_checks++; if (if1.pass_cnt !== 6'd1) $display("FAIL sof_after_done got %0d want 1", if1.pass_cnt); else n_pass++;
        pulse_start(1);
    endtask

    task automatic test_full();
        for (int i = 0; i < 6; i++) begin
            set_exp(2, 1'b1, 5'(i + 1), 32'(100 + i));
            n_checks++;
            if (if2.exp_ready !== (i < 4)) $display("FAIL full_ready%0d got %0h want %0h", i, if2.exp_ready, (i < 4)); else n_pass++;
            tick();
        end
        set_exp(2, 1'b0, 5'd0, 32'd0);
        pulse_start(2);
        for (int i = 0; i < 3; i++) wb(2, 5'(i + 1), 32'(100 + i));
        n_checks++; if (if2.done !== 1'b0) $display("FAIL full_done_early got %0h want 0", if2.done); else n_pass++;
        wb(2, 5'd4, 32'd103);
        n_checks++; if ((if2.done !== 1'b1) || (if2.pass !== 1'b1))
            $display("FAIL full_done_pass got done %0h pass %0h want 1 1", if2.done, if2.pass); else n_pass++;
        n_checks++; if (if2.pass_cnt !== 3'd4) $display("FAIL full_pass_cnt got %0d want 4", if2.pass_cnt); else n_pass++;
        pulse_start(2);
    endtask

    task automatic test_timeout();
        load(2, 5'd5, 32'd50);
        load(2, 5'd6, 32'd60);
        pulse_start(2);
        for (int i = 0; i < 7; i++) tick();
        wb(2, 5'd5, 32'd50);  // pop on the would-be expiry edge wins
        n_checks++; if ((if2.busy !== 1'b1) || (if2.timeout !== 1'b0))
            $display("FAIL to_pop_wins got busy %0h timeout %0h want 1 0", if2.busy, if2.timeout); else n_pass++;
        n_checks++; if (if2.pass_cnt !== 3'd1) $display("FAIL to_pass_cnt got %0d want 1", if2.pass_cnt); else n_pass++;
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if (if2.done !== 1'b0) $display("FAIL to_done_early got %0h want 0", if2.done); else n_pass++;
        tick();
        n_checks++; if ((if2.done !== 1'b1) || (if2.timeout !== 1'b1))
            $display("FAIL to_expired got done %0h timeout %0h want 1 1", if2.done, if2.timeout); else n_pass++;
        n_checks++; if (if2.pass !== 1'b0) $display("FAIL to_pass got %0h want 0", if2.pass); else n_pass++;
        pulse_start(2);
        n_checks++; if (if2.timeout !== 1'b0) $display("FAIL to_rearm got %0h want 0", if2.timeout); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        load(0, 5'd1, 32'd1);
        load(0, 5'd2, 32'd2);
        pulse_start(0);
        wb(0, 5'd1, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ((if0.busy !== 1'b0) || (if0.done !== 1'b0) || (if0.pass_cnt !== 6'd0))
            $display("FAIL rst_run got busy %0h done %0h cnt %0d want 0 0 0", if0.busy, if0.done, if0.pass_cnt); else n_pass++;
        n_checks++; if (if0.exp_ready !== 1'b1) $display("FAIL rst_run_ready got %0h want 1", if0.exp_ready); else n_pass++;
        load(0, 5'd1, 32'd1);
        load(0, 5'd2, 32'd2);
        pulse_start(0);
        wb(0, 5'd1, 32'd1);
        wb(0, 5'd2, 32'd2);
        n_checks++; if ((if0.done !== 1'b1) || (if0.pass !== 1'b1) || (if0.pass_cnt !== 6'd2))
            $display("FAIL rst_rerun got done %0h pass %0h cnt %0d want 1 1 2", if0.done, if0.pass, if0.pass_cnt); else n_pass++;
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            set_exp(u, 1'b0, 5'd0, 32'd0);
            set_wb(u, 1'b0, 5'd0, 32'd0);
            set_start(u, 1'b0);
        end
        test_reset();
        test_basic();
        test_mismatch();
        test_empty_start();
        test_stop_on_fail();
        test_full();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
